// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the TFT-LCD path: pixel-clock divider, H/V counters under an
// IDLE/RUN/DRAIN controller, registered sync/DE decode and a linear frame-buffer address.
module lcd_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_SYNC  = 41,
  parameter int H_BP    = 2,
  parameter int H_ACT   = 480,
  parameter int H_FP    = 2,
  parameter int V_SYNC  = 10,
  parameter int V_BP    = 2,
  parameter int V_ACT   = 272,
  parameter int V_FP    = 2
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        enable,
  output logic        TCLK,
  output logic        pix_en,
  output logic        Hsync,
  output logic        Vsync,
  output logic        hDE,
  output logic        vDE,
  output logic        DE,
  output logic [9:0]  H_COUNT,
  output logic [9:0]  V_COUNT,
  output logic [16:0] BRAMADDR,
  output logic        frame_start
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HA0   = H_SYNC + H_BP;
  localparam int VA0   = V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);
  // 11-bit bounds so that an active region ending exactly at 1024 does not wrap
  localparam logic [10:0]   H_SYNC_X = 11'(H_SYNC);
  localparam logic [10:0]   V_SYNC_X = 11'(V_SYNC);
  localparam logic [10:0]   HA0_X    = 11'(HA0);
  localparam logic [10:0]   VA0_X    = 11'(VA0);
  localparam logic [10:0]   HA1_X    = 11'(HA0 + H_ACT);
  localparam logic [10:0]   VA1_X    = 11'(VA0 + V_ACT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          tclk_q, tclk_d;
  logic          pix_q, pix_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          hde_q, hde_d, vde_q, vde_d, de_q, de_d;
  logic [16:0]   addr_q, addr_d;
  logic          fs_q, fs_d;
  logic          pix_s, run_s;
  logic [10:0]   hx_s, vx_s;

  // Next-state logic: divider, controller, counters, and decode of the next counts
  always_comb begin
    pix_s   = (div_q == DIV_LAST);
    div_d   = pix_s ? '0 : div_q + DW'(1);
    tclk_d  = (div_d < DIV_HALF);
    pix_d   = (div_d == DIV_LAST);
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fs_d    = 1'b0;
    if (pix_s) begin
      case (state_q)
        ST_IDLE: begin
          h_d = 10'd0;
          v_d = 10'd0;
          if (enable) begin
            state_d = ST_RUN;
            fs_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if ((h_q == H_LAST) && (v_q == V_LAST)) begin
            // Frame boundary: the only point where running can stop
            h_d = 10'd0;
            v_d = 10'd0;
            if (enable) begin
              state_d = ST_RUN;
              fs_d    = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            if (h_q == H_LAST) begin
              h_d = 10'd0;
              v_d = v_q + 10'd1;
            end else begin
              h_d = h_q + 10'd1;
              v_d = v_q;
            end
            state_d = enable ? ST_RUN : ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          h_d     = 10'd0;
          v_d     = 10'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    run_s = (state_d != ST_IDLE);
    hx_s  = {1'b0, h_d};
    vx_s  = {1'b0, v_d};
    hs_d  = ~(run_s && (hx_s < H_SYNC_X));
    vs_d  = ~(run_s && (vx_s < V_SYNC_X));
    hde_d = run_s && (hx_s >= HA0_X) && (hx_s < HA1_X);
    vde_d = run_s && (vx_s >= VA0_X) && (vx_s < VA1_X);
    de_d  = hde_d & vde_d;

    addr_d = addr_q;
    if (fs_d) begin
      addr_d = 17'd0;
    end else if (pix_s && de_d) begin
      if ((hx_s == HA0_X) && (vx_s == VA0_X)) begin
        addr_d = 17'd0;
      end else begin
        addr_d = addr_q + 17'd1;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      tclk_q  <= 1'b1;
      pix_q   <= 1'b0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hde_q   <= 1'b0;
      vde_q   <= 1'b0;
      de_q    <= 1'b0;
      addr_q  <= 17'd0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tclk_q  <= tclk_d;
      pix_q   <= pix_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      hde_q   <= hde_d;
      vde_q   <= vde_d;
      de_q    <= de_d;
      addr_q  <= addr_d;
      fs_q    <= fs_d;
    end
  end

  assign TCLK        = tclk_q;
  assign pix_en      = pix_q;
  assign Hsync       = hs_q;
  assign Vsync       = vs_q;
  assign hDE         = hde_q;
  assign vDE         = vde_q;
  assign DE          = de_q;
  assign H_COUNT     = h_q;
  assign V_COUNT     = v_q;
  assign BRAMADDR    = addr_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench for lcd_timing_gen on a small raster: a frame-position reference model
// pushes expected pixel outputs, a monitor pops them whenever the DUT steps a pixel.
module tb_lcd_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int H_SYNC = 3, H_BP = 2, H_ACT = 8, H_FP = 2;
  localparam int V_SYNC = 2, V_BP = 1, V_ACT = 4, V_FP = 1;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HA0 = H_SYNC + H_BP;
  localparam int VA0 = V_SYNC + V_BP;
  localparam int NPIX = H_TOT * V_TOT;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        enable;
  logic        TCLK, pix_en, Hsync, Vsync, hDE, vDE, DE, frame_start;
  logic [9:0]  H_COUNT, V_COUNT;
  logic [16:0] BRAMADDR;

  lcd_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .enable(enable), .TCLK(TCLK), .pix_en(pix_en),
    .Hsync(Hsync), .Vsync(Vsync), .hDE(hDE), .vDE(vDE), .DE(DE),
    .H_COUNT(H_COUNT), .V_COUNT(V_COUNT), .BRAMADDR(BRAMADDR), .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs, vs, hde, vde, de;
    logic [16:0] addr;
    logic        fs;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: running flag, linear position in the frame, last address
  bit m_run;
  int m_p;
  int m_addr;
  int k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_p    = 0;
    m_addr = 0;
  endtask

  task automatic model_step(input bit en);
    exp_t e;
    int   h, v;
    bit   fs;
    fs = 1'b0;
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_p   = 0;
        fs    = 1'b1;
      end
    end else if (m_p == NPIX - 1) begin
      m_p = 0;
      if (en) fs = 1'b1;
      else m_run = 1'b0;
    end else begin
      m_p++;
    end
    h = m_p % H_TOT;
    v = m_p / H_TOT;
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = !(m_run && h < H_SYNC);
    e.vs  = !(m_run && v < V_SYNC);
    e.hde = m_run && h >= HA0 && h < HA0 + H_ACT;
    e.vde = m_run && v >= VA0 && v < VA0 + V_ACT;
    e.de  = e.hde && e.vde;
    if (fs) m_addr = 0;
    if (e.de) m_addr = (v - VA0) * H_ACT + (h - HA0);
    e.addr = 17'(m_addr);
    e.fs   = fs;
    sb_q.push_back(e);
  endtask

  // One CLK of stimulus, driven on the falling edge; divider phase checked here too
  task automatic tick(input bit en);
    @(negedge CLK);
    enable = en;
    check("tclk", 32'(TCLK), 32'((k % CLK_DIV) < CLK_DIV / 2));
    check("pix_en", 32'(pix_en), 32'((k % CLK_DIV) == CLK_DIV - 1));
    if ((k % CLK_DIV) == CLK_DIV - 1) model_step(en);
    k++;
  endtask

  task automatic release_rst(input bit en);
    @(negedge CLK);
    model_reset();
    nRESET = 1'b1;
    enable = en;
    k      = 1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tclk"}, 32'(TCLK), 32'd1);
    check({tag, "_pix_en"}, 32'(pix_en), 32'd0);
    check({tag, "_hcount"}, 32'(H_COUNT), 32'd0);
    check({tag, "_vcount"}, 32'(V_COUNT), 32'd0);
    check({tag, "_hsync"}, 32'(Hsync), 32'd1);
    check({tag, "_vsync"}, 32'(Vsync), 32'd1);
    check({tag, "_hde"}, 32'(hDE), 32'd0);
    check({tag, "_vde"}, 32'(vDE), 32'd0);
    check({tag, "_de"}, 32'(DE), 32'd0);
    check({tag, "_addr"}, 32'(BRAMADDR), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  task automatic wait_pos(input int target);
    int guard;
    guard = 0;
    do begin
      tick(1'b1);
      guard++;
    end while (!(m_run && m_p == target) && guard < 1000);
    check("wait_pos_timeout", 32'(guard < 1000), 32'd1);
  endtask

  // Monitor: every CLK after a pix_en strobe the DUT presents a new pixel
  initial begin
    bit   prev_pix;
    exp_t e;
    prev_pix = 1'b0;
    forever begin
      @(negedge CLK);
      if (nRESET !== 1'b1) begin
        prev_pix = 1'b0;
      end else begin
        if (prev_pix) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: DUT stepped a pixel with no expected entry at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            check("h_count", 32'(H_COUNT), 32'(e.h));
            check("v_count", 32'(V_COUNT), 32'(e.v));
            check("hsync", 32'(Hsync), 32'(e.hs));
            check("vsync", 32'(Vsync), 32'(e.vs));
            check("hde", 32'(hDE), 32'(e.hde));
            check("vde", 32'(vDE), 32'(e.vde));
            check("de", 32'(DE), 32'(e.de));
            check("bramaddr", 32'(BRAMADDR), 32'(e.addr));
            check("frame_start", 32'(frame_start), 32'(e.fs));
          end
        end else begin
          check("frame_start_between", 32'(frame_start), 32'd0);
        end
        prev_pix = pix_en;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    k      = 0;
    enable = 1'b0;
    nRESET = 1'b1;
    #1 nRESET = 1'b0;
    repeat (3) @(negedge CLK);
    #1 check_reset("rst_init");

    release_rst(1'b0);
    repeat (20) tick(1'b0);

    // Continuous run: two full frames and a bit
    repeat (2 * NPIX * CLK_DIV + 10) tick(1'b1);

    // Stop request at (7,4): frame completes, then idle with no frame_start
    wait_pos(4 * H_TOT + 7);
    repeat (300) tick(1'b0);

    // Stop request withdrawn before the frame ends
    wait_pos(4 * H_TOT + 7);
    repeat (30) tick(1'b0);
    repeat (600) tick(1'b1);

    // Random enable segments of varying length
    for (int s = 0; s < 40; s++) begin
      bit en;
      int len;
      en  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 300);
      repeat (len) tick(en);
    end
    repeat (400) tick(1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of the active area at (9,5)
    wait_pos(5 * H_TOT + 9);
    tick(1'b1);
    #2 nRESET = 1'b0;
    #1 check_reset("rst_mid");
    sb_q.delete();
    model_reset();
    release_rst(1'b1);
    n = 0;
    while (frame_start !== 1'b1 && n < 3) begin
      tick(1'b1);
      n++;
    end
    check("fs_after_reset", 32'(frame_start), 32'd1);
    repeat (2 * NPIX * CLK_DIV) tick(1'b1);

    while ((k % CLK_DIV) != 0) tick(enable);
    @(negedge CLK);
    #2 check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
